// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters, holds the grant until the owner
// releases it, then rotates priority so the search starts just past the last owner.
module iob_rr_arbiter #(
  parameter  int N   = 4,
  localparam int N_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           arst_n_i,
  input  logic           cke_i,
  input  logic [N-1:0]   req_i,
  input  logic           release_i,
  output logic [N-1:0]   grant_o,
  output logic [N_W-1:0] grant_id_o,
  output logic           grant_valid_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         r_state;
  logic [N_W-1:0] r_last;
  logic [N-1:0]   r_grant;
  logic [N_W-1:0] r_grant_id;
  logic           r_grant_valid;

  logic [N-1:0]   w_mask;
  logic [N-1:0]   w_masked;
  logic [N_W-1:0] w_sel;
  logic           w_release;

  function automatic logic [N_W-1:0] lowest_idx(input logic [N-1:0] vec);
    logic [N_W-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (vec[k]) begin
        idx = k[N_W-1:0];
      end
    end
    return idx;
  endfunction

  // Priority mask above the last owner, masked-then-unmasked pick, release detect.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (k[N_W-1:0] > r_last) begin
        w_mask[k] = 1'b1;
      end else begin
        w_mask[k] = 1'b0;
      end
    end
    w_masked = req_i & w_mask;
    if (w_masked != '0) begin
      w_sel = lowest_idx(w_masked);
    end else begin
      w_sel = lowest_idx(req_i);
    end
    w_release = release_i | ~req_i[r_grant_id];
  end

  // Arbitration FSM with registered grant outputs; cke_i low freezes everything.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state       <= IDLE;
      r_last        <= N_W'(N - 1);
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
    end else if (cke_i) begin
      case (r_state)
        IDLE: begin
          if (req_i != '0) begin
            r_grant       <= {{(N-1){1'b0}}, 1'b1} << w_sel;
            r_grant_id    <= w_sel;
            r_grant_valid <= 1'b1;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_last        <= r_grant_id;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_grant       <= '0;
          r_grant_id    <= '0;
          r_grant_valid <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign grant_o       = r_grant;
  assign grant_id_o    = r_grant_id;
  assign grant_valid_o = r_grant_valid;

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Directed-vector bench for iob_rr_arbiter (N=4) with per-cycle invariant checks.
module tb_iob_rr_arbiter;

  logic       clk;
  logic       arst_n;
  logic       cke;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  iob_rr_arbiter #(.N(4)) dut (
    .clk_i         (clk),
    .arst_n_i      (arst_n),
    .cke_i         (cke),
    .req_i         (req),
    .release_i     (rel),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [1:0] id);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    check_val({tag, "_valid"}, {31'd0, grant_valid}, 32'd1);
    check_val({tag, "_id"}, {30'd0, grant_id}, {30'd0, id});
    check_val({tag, "_grant"}, {28'd0, grant}, {28'd0, onehot});
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, {31'd0, grant_valid}, 32'd0);
    check_val({tag, "_grant"}, {28'd0, grant}, 32'd0);
    check_val({tag, "_id"}, {30'd0, grant_id}, 32'd0);
  endtask

  // Invariants sampled away from the active edge.
  always @(negedge clk) begin
    if (arst_n) begin
      check_val("inv_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
      check_val("inv_valid_or", {31'd0, grant_valid}, {31'd0, |grant});
      if (grant_valid) begin
        check_val("inv_grant_id", {28'd0, grant}, {28'd0, 4'b0001 << grant_id});
      end
    end
  end

  initial begin
    logic [1:0] fair_seq [4];
    fair_seq[0] = 2'd1; fair_seq[1] = 2'd2; fair_seq[2] = 2'd3; fair_seq[3] = 2'd0;

    arst_n = 1'b0;
    cke    = 1'b1;
    req    = 4'b1111;
    rel    = 1'b0;
    tick();
    tick();
    check_idle("reset");
    arst_n = 1'b1;
    tick();
    check_grant("first_after_reset", 2'd0);

    // Fairness rotation 0 -> 1 -> 2 -> 3 -> 0 with one idle cycle between grants.
    for (int i = 0; i < 4; i++) begin
      rel = 1'b1;
      tick();
      check_idle("fair_gap");
      rel = 1'b0;
      tick();
      check_grant("fair", fair_seq[i]);
    end

    // Serve requester 1 so last owner becomes 1, then wrap to 0.
    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    check_grant("mask_setup1", 2'd1);
    rel = 1'b1;
    req = 4'b0011;
    tick();
    check_idle("mask_gap1");
    rel = 1'b0;
    tick();
    check_grant("mask_wrap", 2'd0);

    rel = 1'b1;
    tick();
    rel = 1'b0;
    tick();
    check_grant("mask_setup2", 2'd1);
    rel = 1'b1;
    req = 4'b1011;
    tick();
    rel = 1'b0;
    tick();
    check_grant("mask_above", 2'd3);

    // Hold: owner 2 keeps the grant while others toggle.
    rel = 1'b1;
    req = 4'b0100;
    tick();
    rel = 1'b0;
    tick();
    check_grant("hold_start", 2'd2);
    for (int i = 0; i < 10; i++) begin
      req = (i % 2 == 0) ? 4'b1101 : 4'b0100;
      tick();
      check_val("hold_id", {30'd0, grant_id}, 32'd2);
      check_val("hold_valid", {31'd0, grant_valid}, 32'd1);
    end

    // Owner drop: grant 1, drop its request, next pick must start past 1.
    rel = 1'b1;
    req = 4'b0010;
    tick();
    rel = 1'b0;
    tick();
    check_grant("drop_start", 2'd1);
    req = 4'b0000;
    tick();
    check_idle("drop_release");
    req = 4'b0110;
    tick();
    check_grant("drop_next", 2'd2);

    // Clock enable low in IDLE blocks arbitration.
    rel = 1'b1;
    req = 4'b0000;
    tick();
    rel = 1'b0;
    cke = 1'b0;
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("cke_hold_idle", {31'd0, grant_valid}, 32'd0);
    end
    cke = 1'b1;
    tick();
    check_grant("cke_resume", 2'd3);
    cke = 1'b0;
    rel = 1'b1;
    tick();
    tick();
    check_grant("cke_hold_busy", 2'd3);
    cke = 1'b1;
    rel = 1'b0;

    // Asynchronous reset while BUSY.
    arst_n = 1'b0;
    #1;
    check_idle("async_reset");
    req = 4'b1111;
    tick();
    arst_n = 1'b1;
    tick();
    check_grant("after_mid_reset", 2'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule

// File: doc/iob_rr_arbiter.md
Name: iob_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource (a memory port or peripheral bus) among N requesters.
- Uses masked/unmasked lowest-index priority selection, LOW mode: the lowest set bit wins.
- Holds a grant until the owner releases it, then rotates priority past the last owner so every requester is eventually served.
- Sits between requesting masters and the shared-resource mux; grant_id_o drives the mux select directly.

Parameters:
- N, 4, number of requesters; N >= 2 required.
- N_W, $clog2(N), width of grant_id_o; derived, not to be overridden.

Ports:
- clk_i  input  1  system clock, rising edge.
- arst_n_i  input  1  asynchronous reset, active low.
- cke_i  input  1  clock enable; when low, all state holds.
- req_i  input  N  per-requester request levels; bit k = requester k.
- release_i  input  1  current owner finishes its transaction this cycle.
- grant_o  output  N  one-hot grant; all zero when idle.
- grant_id_o  output  N_W  index of the granted requester; 0 when idle.
- grant_valid_o  output  1  a grant is active.

Behaviour:
- Reset (arst_n_i low, asynchronous):
  - grant_o=0, grant_id_o=0, grant_valid_o=0.
  - state=IDLE.
  - last_q=N-1, so requester 0 has first priority after reset.
- cke_i=0: state, last_q and all outputs hold; req_i and release_i are ignored.
- FSM states: IDLE, BUSY.
- IDLE, with req_i != 0:
  - mask = bits with index > last_q.
  - sel = lowest set bit of (req_i & mask); if that is zero, sel = lowest set bit of req_i.
  - On the next edge: grant_o=1<<sel, grant_id_o=sel, grant_valid_o=1, state=BUSY.
  - Latency: request sampled at edge t, grant visible after edge t+1 (one cycle).
- IDLE, with req_i == 0: outputs stay zero.
- BUSY, release condition: release_i=1, or req_i[grant_id_o]=0 (owner dropped its request).
- BUSY, on the edge where the release condition is true:
  - last_q=grant_id_o.
  - grant_o=0, grant_id_o=0, grant_valid_o=0.
  - state=IDLE.
- BUSY otherwise: grant is held unchanged regardless of other req_i changes.
- One idle cycle always separates consecutive grants; no back-to-back handover.
- Simultaneous events:
  - release_i together with new requests: the release takes effect; new requests are arbitrated in the following IDLE cycle.
  - release_i in IDLE is ignored.
- Wrap-around:
  - last_q=N-1 makes mask all-zero, so selection falls to the unmasked path (lowest index).
  - A single persistent requester is re-granted after each release, with one idle cycle in between.
- Invariants (asserted in the bench):
  - grant_o is one-hot or zero.
  - grant_valid_o == |grant_o.
  - grant_o == 1<<grant_id_o whenever grant_valid_o=1.
- Reset mid-BUSY: the grant drops immediately (asynchronously) and last_q returns to N-1.
- Implementation: registered outputs only; no combinational path from req_i to grant_o.

Test Plan:
- Reset with req_i=4'b1111 asserted → grant_o=0 during reset. After release of reset, grant_o=4'b0001 and grant_id_o=0 one cycle later.
- Fairness: req_i=4'b1111 held, release_i pulsed each BUSY cycle → grant sequence 0,1,2,3,0, with each grant separated by exactly one idle cycle.
- Masking: last_q=1 (after serving requester 1), req_i=4'b0011 → grants requester 0 via the unmasked wrap. With req_i=4'b1011 → grants requester 3.
- Hold: grant to 2, then toggle req_i[0], req_i[3] for 10 cycles with release_i=0 → grant_id_o stays 2 throughout.
- Owner drop: grant to 1, then req_i[1]→0 with release_i=0 → grant_valid_o=0 next cycle and last_q=1. With req_i=4'b0110 → next grant is 2.
- cke_i/reset: cke_i=0 with req_i=4'b1000 in IDLE for 5 cycles → no grant; cke_i=1 → grant 3 one cycle later. Then arst_n_i=0 while BUSY → grant_o=0 immediately, and the next grant with req_i=4'b1111 is 0.
